control_unit: RTL
=================

Name: control_unit

Overview:
- Hardwired Moore control sequencer for the Mini-SRC datapath.
- Sits directly upstream of Datapath and replaces the bench-driven T0..Tn control sequences.
- Reads the IR, steps through fetch, decode and execute, and drives every datapath strobe: register select (Gra/Grb/Grc), ALU opcode, Y/Z/HI/LO/MAR/MDR/PC enables.
- Covers register-format ALU, mul/div, neg/not, nop and halt.

Parameters:
- OPW, 5, opcode field width; IR[31:27].
- RESET_PC_HOLD, 1, cycles spent in S_RESET after clear deasserts before the first fetch.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- clear  in  1  synchronous, active-high reset.
- IR  in  32  instruction register from Datapath. Fields: op=IR[31:27], ra=IR[26:23], rb=IR[22:19], rc=IR[18:15].
- mem_ready  in  1  memory read-data valid; stalls fetch.
- PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin  out  1 each  fetch strobes.
- Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout  out  1 each  execute strobes.
- Gra, Grb, Grc, Rin, Rout  out  1 each  select/encode strobes to the register file.
- opcode  out  5  ALU operation select; equals op during ALU-compute steps, else 5'b00000.
- run  out  1  high unless halted.
- illegal  out  1  one-cycle pulse on decode of an unsupported opcode.
- step  out  4  present state encoding, for debug.

Behaviour:
- Reset and outputs:
  - clear=1 at a posedge → state S_RESET.
  - While clear=1, all strobes, opcode and illegal are 0, and run is 1.
  - Outputs are a pure decode of the present state (plus op for opcode). No strobe is asserted in two consecutive states unless listed.
- Opcode map: add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001, and 01010, or 01011, mul 01111, div 10000, neg 10001, not 10010, nop 11010, halt 11011.
- S_RESET: no strobes. After RESET_PC_HOLD cycles → T0.
- T0: PCout, MARin, IncPC, PCin. → T1.
- T1: Read, MDRin.
  - Stay in T1 while mem_ready=0.
  - → T2 on the cycle mem_ready=1.
  - Read/MDRin remain high for every stall cycle.
- T2: MDRout, IRin. → T3. IR is valid from T3 onward.
- ALU class (add..or):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, opcode=op, Zlowin.
  - T5: Zlowout, Gra, Rin. → T0.
- mul/div:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, opcode=op, Zlowin, Zhighin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin. → T0.
- neg/not:
  - T3: Grb, Rout, opcode=op, Zlowin.
  - T4: Zlowout, Gra, Rin. → T0.
- nop: T3 has no strobes. → T0.
- halt: T3 → S_HALT. run=0 and no strobes. Stays in S_HALT until clear.
- Unsupported opcode: treated as nop, with illegal=1 during T3 only.
- Total latency per instruction with mem_ready tied high:
  - ALU class: 6 cycles (T0..T5).
  - mul/div: 7 cycles.
  - neg/not: 5 cycles.
  - nop: 4 cycles.
- Each extra low cycle of mem_ready adds one cycle in T1.
- clear mid-instruction: the state machine abandons the instruction at the next posedge. The partially executed instruction has no further strobes.
- mem_ready high outside T1 is ignored. mem_ready never skips T1: the minimum T1 residency is 1 cycle.
- IR changes outside T3..T6 do not affect the current sequence. opcode and Gr* decode use the IR value present in each cycle.

Test Plan:
- clear=1 for 2 cycles, then 0 → all strobes 0 during clear; with RESET_PC_HOLD=1, T0 strobes (PCout, MARin, IncPC, PCin) appear 1 cycle after release.
- IR=32'h30918000 (shra R1,R2,R3), mem_ready=1, R2=0xFFFFFFBB, R3=3 → T4 opcode=00110, Zlowin=1. At T5, R1 receives 0xFFFFFFF7. Next T0 occurs 6 cycles after the previous T0.
- mem_ready held low 3 cycles in T1 → Read=MDRin=1 for 4 cycles; IRin asserts exactly once, in the cycle after mem_ready=1.
- IR=mul R4,R5 (32'h7A280000), R4=6, R5=7 → Zlowin=Zhighin=1 in T4; LOin in T5 with LO=42; HIin in T6 with HI=0. Next fetch 7 cycles after the previous T0.
- IR op=11111 → illegal pulses for exactly 1 cycle in T3, no Rin/Yin/Zin asserted, next T0 follows.
- IR op=11011 (halt) → run drops to 0 in S_HALT and stays 0 for 20 cycles with no strobes. A clear pulse restores run=1 and fetch restarts.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the Mini-SRC datapath.
// Steps fetch (T0..T2), decodes the opcode in T3 and walks a per-class
// execute path, driving register-select, ALU and Y/Z/HI/LO/MAR/MDR/PC strobes.
// Outputs are a decode of the present state and the IR in the same cycle, so
// opcode and Gr* always reflect the instruction currently on IR.
module control_unit #(
    parameter int OPW           = 5,
    parameter int RESET_PC_HOLD = 1
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [31:0]    IR,
    input  logic           mem_ready,
    output logic           PCout,
    output logic           IncPC,
    output logic           PCin,
    output logic           MARin,
    output logic           Read,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Yin,
    output logic           Zlowin,
    output logic           Zhighin,
    output logic           Zlowout,
    output logic           Zhighout,
    output logic           HIin,
    output logic           LOin,
    output logic           HIout,
    output logic           LOout,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic [OPW-1:0] opcode,
    output logic           run,
    output logic           illegal,
    output logic [3:0]     step
);

    // State encoding doubles as the debug step value.
    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_T0     = 4'd1,
        S_T1     = 4'd2,
        S_T2     = 4'd3,
        S_T3     = 4'd4,
        S_ALU_T4 = 4'd5,
        S_ALU_T5 = 4'd6,
        S_MD_T4  = 4'd7,
        S_MD_T5  = 4'd8,
        S_MD_T6  = 4'd9,
        S_UN_T4  = 4'd10,
        S_HALT   = 4'd15
    } state_t;

    // Instruction classes; each class owns its own execute path after T3.
    typedef enum logic [2:0] {
        C_ALU,
        C_MULDIV,
        C_UNARY,
        C_NOP,
        C_HALT,
        C_ILLEGAL
    } op_class_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01011);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    // Reset hold counter: counts cycles spent in S_RESET after clear drops.
    // A hold of 0 still costs the one S_RESET cycle that clear leaves behind.
    localparam int HOLD_W = (RESET_PC_HOLD > 1) ? $clog2(RESET_PC_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((RESET_PC_HOLD > 1) ? RESET_PC_HOLD - 1 : 0);

    state_t            state;
    op_class_t         op_class;
    logic [HOLD_W-1:0] hold_cnt;
    logic [OPW-1:0]    op;

    // Register fields are decoded by the register file from Gra/Grb/Grc.
    logic unused_ir_fields;

    assign op               = IR[31 -: OPW];
    assign unused_ir_fields = ^IR[31-OPW:0];
    assign step             = state;

    // Classify the opcode currently on IR.
    always_comb begin
        // NOTE: give every combinational output a default before any branch so no path infers a latch.
        op_class = C_ILLEGAL;
        if (op >= OP_ADD && op <= OP_OR) begin
            op_class = C_ALU;
        end else if (op == OP_MUL || op == OP_DIV) begin
            op_class = C_MULDIV;
        end else if (op == OP_NEG || op == OP_NOT) begin
            op_class = C_UNARY;
        end else if (op == OP_NOP) begin
            op_class = C_NOP;
        end else if (op == OP_HALT) begin
            op_class = C_HALT;
        end
    end

    // Sequencer: fetch, decode on T3, then the class-specific execute path.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (clear) begin
            state    <= S_RESET;
            hold_cnt <= '0;
        end else begin
            case (state)
                S_RESET: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= S_T0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_T0:     state <= S_T1;
                S_T1:     if (mem_ready) state <= S_T2;
                S_T2:     state <= S_T3;
                S_T3: begin
                    case (op_class)
                        C_ALU:    state <= S_ALU_T4;
                        C_MULDIV: state <= S_MD_T4;
                        C_UNARY:  state <= S_UN_T4;
                        C_HALT:   state <= S_HALT;
                        default:  state <= S_T0;
                    endcase
                end
                S_ALU_T4: state <= S_ALU_T5;
                S_ALU_T5: state <= S_T0;
                S_MD_T4:  state <= S_MD_T5;
                S_MD_T5:  state <= S_MD_T6;
                S_MD_T6:  state <= S_T0;
                S_UN_T4:  state <= S_T0;
                S_HALT:   state <= S_HALT;
                default:  state <= S_RESET;
            endcase
        end
    end

    // Strobe decode of the present state; clear forces everything quiet at once.
    always_comb begin
        PCout    = 1'b0;
        IncPC    = 1'b0;
        PCin     = 1'b0;
        MARin    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowin   = 1'b0;
        Zhighin  = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        opcode   = '0;
        illegal  = 1'b0;
        run      = 1'b1;
        if (!clear) begin
            case (state)
                S_T0: begin
                    PCout = 1'b1;
                    MARin = 1'b1;
                    IncPC = 1'b1;
                    PCin  = 1'b1;
                end
                S_T1: begin
                    Read  = 1'b1;
                    MDRin = 1'b1;
                end
                S_T2: begin
                    MDRout = 1'b1;
                    IRin   = 1'b1;
                end
                S_T3: begin
                    case (op_class)
                        C_ALU: begin
                            Grb  = 1'b1;
                            Rout = 1'b1;
                            Yin  = 1'b1;
                        end
                        C_MULDIV: begin
                            Gra  = 1'b1;
                            Rout = 1'b1;
                            Yin  = 1'b1;
                        end
                        C_UNARY: begin
                            Grb    = 1'b1;
                            Rout   = 1'b1;
                            opcode = op;
                            Zlowin = 1'b1;
                        end
                        C_ILLEGAL: illegal = 1'b1;
                        default: ;
                    endcase
                end
                S_ALU_T4: begin
                    Grc    = 1'b1;
                    Rout   = 1'b1;
                    opcode = op;
                    Zlowin = 1'b1;
                end
                S_ALU_T5, S_UN_T4: begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end
                S_MD_T4: begin
                    Grb     = 1'b1;
                    Rout    = 1'b1;
                    opcode  = op;
                    Zlowin  = 1'b1;
                    Zhighin = 1'b1;
                end
                S_MD_T5: begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end
                S_MD_T6: begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
                S_HALT:  run = 1'b0;
                default: ;
            endcase
        end
    end

endmodule
